multi_step_driver: RTL and testbench

Parametrised successor to the single-drive stepper coil driver. It converts the floppy bus STEP/DIR/drive-select lines into 4-coil stepper patterns for up to NUM_DRIVES emulated drives. It adds wave, two-phase full-step and half-step modes, a per-drive head-position counter with track-0 and end-stop clamping, and a minimum step interval with missed-step reporting. It sits between the bus input synchroniser and the stepper power stage; track outputs feed the track-data fetch logic.

---
 rtl/multi_step_driver_pkg.sv | 32 +++
 rtl/multi_step_driver_step_channel.sv | 95 +++++++++
 rtl/multi_step_driver.sv | 72 +++++++
 tb/tb_multi_step_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_step_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_step_pkg
// Purpose  : Shared mode/direction encodings and coil pattern lookup.
// Revision : 1.0
// ============================================================================
package multi_step_pkg;

   localparam logic [1:0] MODE_WAVE = 2'b00;
   localparam logic [1:0] MODE_FULL = 2'b01;
   localparam logic [1:0] MODE_HALF = 2'b10;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   function automatic logic [3:0] coil_of_idx(input logic [2:0] idx);
      logic [3:0] pat;
      case (idx)
         3'd0:    pat = 4'b0001;
         3'd1:    pat = 4'b0011;
         3'd2:    pat = 4'b0010;
         3'd3:    pat = 4'b0110;
         3'd4:    pat = 4'b0100;
         3'd5:    pat = 4'b1100;
         3'd6:    pat = 4'b1000;
         default: pat = 4'b1001;
      endcase
      return pat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_step_driver_step_channel.sv
`default_nettype none
// ============================================================================
// Module   : step_channel
// Purpose  : One stepper channel: phase index, half-step position, rate limit.
// Revision : 1.0
// ============================================================================
module step_channel
   import multi_step_pkg::*;
#(
   parameter int MAX_TRACK       = 79,
   parameter int INIT_TRACK      = 0,
   parameter int MIN_STEP_CYCLES = 16,
   parameter int TW              = $clog2(MAX_TRACK + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step_edge,
   input  logic          dir,
   input  logic          sel,
   input  logic [1:0]    mode,
   output logic [3:0]    coils,
   output logic [TW-1:0] track,
   output logic          tr0,
   output logic          missed
);

   localparam int PW = TW + 1;
   localparam int CW = (MIN_STEP_CYCLES > 1) ? $clog2(MIN_STEP_CYCLES) : 1;
   localparam logic [PW-1:0] POS_MAX   = PW'(2 * MAX_TRACK);
   localparam logic [PW-1:0] POS_INIT  = PW'(2 * INIT_TRACK);
   localparam logic [CW-1:0] RATE_LOAD = CW'(MIN_STEP_CYCLES - 1);

   logic [2:0]    idx_q, idx_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [CW-1:0] rate_q, rate_d;
   logic          missed_q, missed_d;

   logic [1:0]    w_base;
   logic [1:0]    w_move;
   logic [PW-1:0] w_room;
   logic [PW-1:0] w_move_ext;
   logic          w_accept;

   always_comb begin
      // Wave lands on even phases, full-step on odd ones.
      case (mode)
         MODE_HALF: w_base = 2'd1;
         MODE_FULL: w_base = idx_q[0] ? 2'd2 : 2'd1;
         default:   w_base = idx_q[0] ? 2'd1 : 2'd2;
      endcase

      // Distance to the end stop in the requested direction bounds the move.
      w_room     = (dir == DIR_OUT) ? pos_q : (POS_MAX - pos_q);
      w_move     = (w_room < PW'(w_base)) ? w_room[1:0] : w_base;
      w_move_ext = PW'(w_move);
      w_accept   = step_edge & sel & (rate_q == '0) & (w_move != 2'd0);

      idx_d    = idx_q;
      pos_d    = pos_q;
      rate_d   = (rate_q != '0) ? (rate_q - CW'(1)) : rate_q;
      missed_d = step_edge & sel & (rate_q != '0);

      if (w_accept) begin
         rate_d = RATE_LOAD;
         if (dir == DIR_OUT) begin
            idx_d = idx_q - {1'b0, w_move};
            pos_d = pos_q - w_move_ext;
         end else begin
            idx_d = idx_q + {1'b0, w_move};
            pos_d = pos_q + w_move_ext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= 3'd0;
         pos_q    <= POS_INIT;
         rate_q   <= '0;
         missed_q <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         pos_q    <= pos_d;
         rate_q   <= rate_d;
         missed_q <= missed_d;
      end
   end

   assign coils  = coil_of_idx(idx_q);
   assign track  = pos_q[PW-1:1];
   assign tr0    = (pos_q == '0);
   assign missed = missed_q;

endmodule
`default_nettype wire

// File: rtl/multi_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : multi_step_driver
// Purpose  : Bus STEP/DIR/SEL sampling and fan-out to per-drive step channels.
// Revision : 1.0
// ============================================================================
module multi_step_driver #(
   parameter int NUM_DRIVES      = 2,
   parameter int MAX_TRACK       = 79,
   parameter int INIT_TRACK      = 0,
   parameter int MIN_STEP_CYCLES = 16,
   parameter int TW              = $clog2(MAX_TRACK + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     step,
   input  logic                     dir,
   input  logic [NUM_DRIVES-1:0]    sel,
   input  logic [1:0]               mode,
   output logic [4*NUM_DRIVES-1:0]  coils,
   output logic [TW*NUM_DRIVES-1:0] track,
   output logic [NUM_DRIVES-1:0]    tr0,
   output logic [NUM_DRIVES-1:0]    missed
);

   logic                  step_q, step_qq;
   logic                  dir_q;
   logic [1:0]            mode_q;
   logic [NUM_DRIVES-1:0] sel_q;
   logic                  w_step_edge;

   // Edge history resets high so a STEP held through reset is not a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q  <= 1'b1;
         step_qq <= 1'b1;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
         sel_q   <= '0;
      end else begin
         step_q  <= step;
         step_qq <= step_q;
         dir_q   <= dir;
         mode_q  <= mode;
         sel_q   <= sel;
      end
   end

   assign w_step_edge = step_q & ~step_qq;

   for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ch
      step_channel #(
         .MAX_TRACK       (MAX_TRACK),
         .INIT_TRACK      (INIT_TRACK),
         .MIN_STEP_CYCLES (MIN_STEP_CYCLES),
         .TW              (TW)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .step_edge (w_step_edge),
         .dir       (dir_q),
         .sel       (sel_q[i]),
         .mode      (mode_q),
         .coils     (coils[4*i +: 4]),
         .track     (track[TW*i +: TW]),
         .tr0       (tr0[i]),
         .missed    (missed[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_step_driver
// Purpose  : Directed scoreboard bench for multi_step_driver.
// Revision : 1.0
// ============================================================================
module tb_multi_step_driver;

   localparam int ND = 2;
   localparam int MT = 79;
   localparam int IT = 0;
   localparam int MS = 16;
   localparam int TW = $clog2(MT + 1);

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 step  = 1'b1;
   logic                 dir   = 1'b0;
   logic [ND-1:0]        sel   = '0;
   logic [1:0]           mode  = 2'b00;
   logic [4*ND-1:0]      coils;
   logic [TW*ND-1:0]     track;
   logic [ND-1:0]        tr0;
   logic [ND-1:0]        missed;

   multi_step_driver #(
      .NUM_DRIVES      (ND),
      .MAX_TRACK       (MT),
      .INIT_TRACK      (IT),
      .MIN_STEP_CYCLES (MS),
      .TW              (TW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step),
      .dir    (dir),
      .sel    (sel),
      .mode   (mode),
      .coils  (coils),
      .track  (track),
      .tr0    (tr0),
      .missed (missed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            ch;
      logic [3:0]    coils;
      logic [TW-1:0] track;
      logic          tr0;
      logic          missed;
   } exp_t;

   exp_t sb[$];

   int   m_idx  [ND];
   int   m_pos  [ND];
   int   m_last [ND];
   logic m_miss [ND];

   int checks = 0;
   int errors = 0;

   function automatic logic [3:0] ref_coil(input int i);
      logic [3:0] p;
      case (i)
         0:       p = 4'b0001;
         1:       p = 4'b0011;
         2:       p = 4'b0010;
         3:       p = 4'b0110;
         4:       p = 4'b0100;
         5:       p = 4'b1100;
         6:       p = 4'b1000;
         default: p = 4'b1001;
      endcase
      return p;
   endfunction

   task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s ch%0d observed %0h expected %0h", tag, ch, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < ND; c++) begin
         m_idx[c]  = 0;
         m_pos[c]  = 2 * IT;
         m_last[c] = -1000;
         m_miss[c] = 1'b0;
      end
   endtask

   // Walks one phase at a time until the mode's landing phase or an end stop.
   task automatic model_step(input logic d, input logic [1:0] m, input logic [ND-1:0] s, input int e0);
      for (int c = 0; c < ND; c++) begin
         m_miss[c] = 1'b0;
         if (s[c]) begin
            if (e0 - m_last[c] < MS) begin
               m_miss[c] = 1'b1;
            end else begin
               int moved = 0;
               for (int k = 0; k < 2; k++) begin
                  if (!d && m_pos[c] == 2 * MT) break;
                  if (d && m_pos[c] == 0) break;
                  m_pos[c] = m_pos[c] + (d ? -1 : 1);
                  m_idx[c] = (m_idx[c] + (d ? 7 : 1)) % 8;
                  moved++;
                  if (m == 2'b10) break;
                  if ((m == 2'b00 || m == 2'b11) && (m_idx[c] % 2 == 0)) break;
                  if (m == 2'b01 && (m_idx[c] % 2 == 1)) break;
               end
               if (moved > 0) m_last[c] = e0;
            end
         end
      end
   endtask

   task automatic push_all();
      for (int c = 0; c < ND; c++) begin
         exp_t e;
         e.ch     = c;
         e.coils  = ref_coil(m_idx[c]);
         e.track  = TW'(m_pos[c] / 2);
         e.tr0    = (m_pos[c] == 0);
         e.missed = m_miss[c];
         sb.push_back(e);
      end
   endtask

   task automatic check_sb(input string tag);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({tag, ".coils"},  e.ch, 32'(coils[4*e.ch +: 4]),   32'(e.coils));
         chk({tag, ".track"},  e.ch, 32'(track[TW*e.ch +: TW]), 32'(e.track));
         chk({tag, ".tr0"},    e.ch, 32'(tr0[e.ch]),            32'(e.tr0));
         chk({tag, ".missed"}, e.ch, 32'(missed[e.ch]),         32'(e.missed));
      end
   endtask

   // E0 is the posedge after the first negedge; results are compared after E1.
   task automatic drive_step(input string tag, input logic d, input logic [1:0] m,
                             input logic [ND-1:0] s, input int gap);
      @(negedge clk);
      dir  = d;
      mode = m;
      sel  = s;
      step = 1'b1;
      model_step(d, m, s, cyc + 1);
      push_all();
      @(negedge clk);
      @(negedge clk);
      step = 1'b0;
      check_sb(tag);
      @(negedge clk);
      for (int c = 0; c < ND; c++) chk({tag, ".missed_width"}, c, 32'(missed[c]), 32'd0);
      repeat (gap - 3) @(negedge clk);
   endtask

   // STEP is held high across reset release and must not register as a request.
   task automatic reset_dut(input string tag);
      @(negedge clk);
      step  = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      push_all();
      repeat (3) @(negedge clk);
      check_sb({tag, ".held"});
      step = 1'b0;
      repeat (2) @(negedge clk);
      push_all();
      check_sb({tag, ".release"});
   endtask

   initial begin
      model_reset();

      reset_dut("rst0");

      drive_step("wave1", 1'b0, 2'b00, 2'b01, 19);
      drive_step("wave2", 1'b0, 2'b00, 2'b01, 19);
      drive_step("wave3", 1'b0, 2'b00, 2'b01, 19);

      reset_dut("rst1");
      drive_step("half1", 1'b0, 2'b10, 2'b01, 19);
      drive_step("half2", 1'b0, 2'b10, 2'b01, 19);
      drive_step("full1", 1'b0, 2'b01, 2'b01, 19);
      drive_step("mode3", 1'b0, 2'b11, 2'b01, 19);
      drive_step("out1",  1'b1, 2'b01, 2'b01, 19);

      reset_dut("rst2");
      drive_step("out_at0", 1'b1, 2'b00, 2'b01, 19);
      for (int n = 0; n < MT; n++) drive_step("seek", 1'b0, 2'b00, 2'b01, 16);
      drive_step("endstop", 1'b0, 2'b00, 2'b01, 16);
      drive_step("endstop_half", 1'b0, 2'b10, 2'b01, 16);
      drive_step("back_out", 1'b1, 2'b10, 2'b01, 16);

      reset_dut("rst3");
      drive_step("rate_a", 1'b0, 2'b00, 2'b01, 4);
      drive_step("rate_b", 1'b0, 2'b00, 2'b01, 19);
      drive_step("rate_c", 1'b0, 2'b00, 2'b01, 19);

      drive_step("both", 1'b0, 2'b00, 2'b11, 19);
      drive_step("ch1_only", 1'b0, 2'b10, 2'b10, 19);

      // Reset asserted one cycle after E0 of a two-channel step.
      @(negedge clk);
      dir  = 1'b0;
      mode = 2'b00;
      sel  = 2'b11;
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      push_all();
      check_sb("midrst.async");
      step = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      push_all();
      check_sb("midrst.after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
